// File: rtl/rr_line_sequencer.sv
// Round-robin sequencer over eight request lines that drives a one-hot decoder select code {x,y,z}.
// Optional grant watchdog is compiled in with RR_SEQ_TIMEOUT_EN.
module rr_line_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       en,
  output logic [2:0] idx,
  output logic       err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] code_q, code_d;
  logic [2:0] last_q, last_d;
  logic       en_q, en_d;
  logic [2:0] pick;
  logic       found;
  logic       abort;

  // First requester strictly after the last acknowledged index, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && req[3'(last_q + 3'(k))]) begin
        pick  = 3'(last_q + 3'(k));
        found = 1'b1;
      end
    end
  end

`ifdef RR_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign abort = (state_q == S_GRANT) && !ack && (8'(cnt_q + 8'd1) == 8'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == S_IDLE && found) cnt_d = '0;
    else if (state_q == S_GRANT)    cnt_d = 8'(cnt_q + 8'd1);
    if (abort) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    last_d  = last_q;
    en_d    = en_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = pick;
          code_d  = ~pick;
          en_d    = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // ack takes precedence over a simultaneous watchdog abort
        if (ack) begin
          last_d  = idx_q;
          en_d    = 1'b0;
          state_d = S_GAP;
        end else if (abort) begin
          en_d    = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      code_q  <= 3'b111;
      last_q  <= 3'd7;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      last_q  <= last_d;
      en_q    <= en_d;
    end
  end

  assign {x, y, z} = code_q;
  assign idx       = idx_q;
  assign en        = en_q;

endmodule

// File: tb/tb_rr_line_sequencer.sv
// Directed plus randomized bench for rr_line_sequencer against a transaction-level round-robin model.
module tb_rr_line_sequencer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ack = 1'b0;
  logic       x, y, z, en, err;
  logic [2:0] idx;

  int checks = 0;
  int errors = 0;
  int last   = 7;   // model: last acknowledged index
  int held   = 0;   // model: index whose code is currently presented

  rr_line_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .x(x), .y(y), .z(z), .en(en), .idx(idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int winner(input logic [7:0] r, input int l);
    for (int k = 1; k <= 8; k++)
      if (r[(l + k) % 8]) return (l + k) % 8;
    return -1;
  endfunction

  task automatic chk_code(input string tag, input int i);
    logic [2:0] wi, cw;
    wi = i[2:0];
    cw = ~wi;
    chk({tag, "_idx"}, {5'd0, idx}, {5'd0, wi});
    chk({tag, "_code"}, {5'd0, x, y, z}, {5'd0, cw});
  endtask

  // One full grant: IDLE->GRANT, dly cycles without ack (req = hr), ack, GAP, back to IDLE.
  task automatic grant(input logic [7:0] r, input logic [7:0] hr, input int dly);
    int w;
    w = winner(r, last);
    req = r; ack = 1'b0;
    tick;
    chk("grant_en", {7'd0, en}, 8'd1);
    chk("grant_err", {7'd0, err}, 8'd0);
    chk_code("grant", w);
    held = w;
    req = hr;
    repeat (dly) begin
      tick;
      chk("hold_en", {7'd0, en}, 8'd1);
      chk_code("hold", w);
    end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("gap_en", {7'd0, en}, 8'd0);
    chk("gap_err", {7'd0, err}, 8'd0);
    chk_code("gap", w);
    last = w;
    req = 8'($urandom); ack = 1'($urandom);
    tick;
    chk("idle_en", {7'd0, en}, 8'd0);
    ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req = 8'h00;
    repeat (n) begin
      ack = 1'($urandom);
      tick;
      chk("idle_quiet_en", {7'd0, en}, 8'd0);
      chk_code("idle_quiet", held);
    end
    ack = 1'b0;
  endtask

`ifdef RR_SEQ_TIMEOUT_EN
  task automatic watchdog(input logic [7:0] r, input bit ack_at_limit);
    int w;
    w = winner(r, last);
    req = r; ack = 1'b0;
    tick;
    chk("wd_en", {7'd0, en}, 8'd1);
    chk_code("wd", w);
    held = w;
    req = 8'($urandom);
    repeat (TO - 1) begin
      tick;
      chk("wd_hold_en", {7'd0, en}, 8'd1);
      chk("wd_hold_err", {7'd0, err}, 8'd0);
    end
    ack = ack_at_limit;
    tick;
    ack = 1'b0;
    chk("wd_end_en", {7'd0, en}, 8'd0);
    chk("wd_end_err", {7'd0, err}, ack_at_limit ? 8'd0 : 8'd1);
    chk_code("wd_end", w);
    if (ack_at_limit) last = w;
    tick;
    chk("wd_after_err", {7'd0, err}, 8'd0);
    chk("wd_after_en", {7'd0, en}, 8'd0);
  endtask
`endif

  initial begin
    logic [7:0] r;
    // reset held with all requests active
    req = 8'hFF;
    repeat (3) tick;
    chk("rst_en", {7'd0, en}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk_code("rst", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // full rotation with wrap 7 -> 0
    repeat (9) grant(8'hFF, 8'hFF, 0);

    // sparse with wrap: serve 7, then 1,7,1
    grant(8'h80, 8'h80, 0);
    grant(8'h82, 8'h82, 0);
    grant(8'h82, 8'h82, 1);
    grant(8'h82, 8'h82, 0);

    // hold rule: drop req[3], raise req[5] during grant of 3
    grant(8'h08, 8'h20, 2);
    grant(8'h28, 8'h28, 0);

    idle_cycles(3);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      r = 8'($urandom);
      if (r == 8'h00) r = 8'h01 << $urandom_range(0, 7);
      grant(r, 8'($urandom), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

`ifdef RR_SEQ_TIMEOUT_EN
    last = 1;
    grant(8'h02, 8'h02, 0);
    watchdog(8'h04, 1'b0);
    grant(8'h04, 8'h04, 0);
    watchdog(8'h10, 1'b1);
    grant(8'h14, 8'h14, 0);
`else
    grant(8'h40, 8'h00, 20);
    chk("no_wd_err", {7'd0, err}, 8'd0);
`endif

    // async reset mid-grant
    req = 8'hFF;
    tick;
    chk("pre_rst_en", {7'd0, en}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", {7'd0, en}, 8'd0);
    chk("async_rst_err", {7'd0, err}, 8'd0);
    chk_code("async_rst", 0);
    last = 7; held = 0;
    @(negedge clk);
    rst_n = 1'b1;
    grant(8'hFF, 8'hFF, 0);
    grant(8'hFF, 8'hFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
